fixp_square_iter: RTL and testbench
===================================

Name: fixp_square_iter

Overview:
- Iterative unsigned fixed-point squarer. It is the inverse companion of the sqrt block and uses the same Q16.16 data format.
- Computes y = x*x in Q16.16 with saturation, using one shift-add step per clock.
- Feeds sqrt results back for self-check and serves as the squaring stage in the basic arithmetic library.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- FRAC, 16, number of fractional bits (Q(WIDTH-FRAC).FRAC).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- squarer  input  WIDTH  operand x, unsigned Q16.16.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- squared  output  WIDTH  result, unsigned Q16.16.
- overflow  output  1  result saturated; qualified by out_valid.

Behaviour:
- Single clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, squared=0, overflow=0. FSM goes to IDLE; accumulator and counter are cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch multiplicand = zero-extended x (2*WIDTH bits) and multiplier = x; clear the 2*WIDTH-bit accumulator; set cnt=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: if multiplier[0], then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - After WIDTH steps (cnt == WIDTH-1 on the final step), register the final result and go to DONE.
- Result rule:
  - full = acc (2*WIDTH bits); q = full >> FRAC (truncate).
  - If q[2*WIDTH-FRAC-1:WIDTH] != 0: squared = all ones, overflow=1. Otherwise squared = q[WIDTH-1:0], overflow=0.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge (32 cycles by default).
- DONE:
  - out_valid=1; squared and overflow are held stable until out_ready.
  - On out_ready at an edge: out_valid=0 and go to IDLE. in_ready returns to 1 on the following cycle. There is no same-cycle accept during DONE.
- in_valid during CALC or DONE is ignored; the operand is not captured.
- Operand x=0: the result is 0 after the full WIDTH cycles. There is no early termination, so latency is fixed.
- Reset mid-operation, in any state: the operation is aborted, no result is produced, and all outputs take their reset values.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro FIXP_SQUARE_ROUND_EN.
- Defined: round to nearest. q = (full + (1 << (FRAC-1))) >> FRAC, applied before the saturation check. The add is done at 2*WIDTH+1 bits so no carry is lost. Latency is unchanged.
- Undefined: truncation as described in Behaviour.

Decomposition:
- Shared package fixp_pkg:
  - FIXP_WIDTH = 32 and FIXP_FRAC = 16 default constants.
  - Q16.16 typedef.
  - FSM state encoding (IDLE, CALC, DONE).
  - FIXP_ONE = 32'h00010000.
- One sub-module is natural: fixp_sat_round. It is combinational; it takes 2*WIDTH in and gives WIDTH out plus the overflow flag. It holds the rounding and saturation logic and the FIXP_SQUARE_ROUND_EN switch, and can be reused by other multipliers.
- The FSM and shift-add datapath stay in fixp_square_iter.

Test Plan:
- Reset then x=32'h00020000 (2.0), out_ready=1 → squared=32'h00040000, overflow=0, out_valid high exactly 32 cycles after accept.
- x=32'h00018000 (1.5) → 32'h00024000. x=32'h00000100 → 32'h00000001. x=0 → 0 after 32 cycles.
- x=32'h01000000 (256.0) → squared=32'hFFFFFFFF, overflow=1. x=32'h00FFFFFF → 32'hFFFFFE00, overflow=0.
- Rounding check, x=32'h00000160:
  - Without macro → 32'h00000001.
  - With FIXP_SQUARE_ROUND_EN → 32'h00000002.
- Backpressure: hold out_ready=0 for 10 cycles after done → squared stays stable, in_ready=0, and a new in_valid is not captured. Release → in_ready=1 the next cycle.
- Assert rst_n=0 for one edge at cycle 15 of CALC → out_valid never rises for that operand, in_ready=1 after reset. A new x=32'h00030000 then gives 32'h00090000.

Source files
------------

// File: rtl/fixp_pkg.sv
// Shared fixed-point definitions for the arithmetic library:
// Q16.16 defaults, the Q16.16 data type, the unit constant and the
// encoding of the iterative-unit state machine.
package fixp_pkg;

  localparam int FIXP_WIDTH = 32;
  localparam int FIXP_FRAC  = 16;

  typedef logic [FIXP_WIDTH-1:0] q16_16_t;

  localparam q16_16_t FIXP_ONE = 32'h00010000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fixp_state_t;

endpackage

// File: rtl/fixp_sat_round.sv
// Combinational result stage for fixed-point multipliers: takes the
// 2*WIDTH-bit full product, drops FRAC fractional bits and saturates to
// WIDTH bits.
// Build option: define FIXP_SQUARE_ROUND_EN to round to nearest (half up)
// instead of truncating.
module fixp_sat_round
  import fixp_pkg::*;
#(
  parameter int WIDTH = FIXP_WIDTH,
  parameter int FRAC  = FIXP_FRAC
) (
  input  logic [2*WIDTH-1:0] i_full,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_overflow
);

  // Quotient width after the shift, including the extra carry bit.
  localparam int QW = 2*WIDTH + 1 - FRAC;

  logic [2*WIDTH:0] w_sum;
  logic [QW-1:0]    w_q;

  // Optional half-LSB bias, then drop the fraction and saturate.
  always_comb begin
`ifdef FIXP_SQUARE_ROUND_EN
    // One extra bit of headroom so the rounding carry is never lost.
    w_sum = {1'b0, i_full} + ((2*WIDTH+1)'(1) << (FRAC-1));
`else
    w_sum = {1'b0, i_full};
`endif
    w_q        = w_sum[2*WIDTH:FRAC];
    o_overflow = |w_q[QW-1:WIDTH];
    o_result   = o_overflow ? {WIDTH{1'b1}} : w_q[WIDTH-1:0];
  end

endmodule

// File: rtl/fixp_square_iter.sv
// Iterative unsigned Q16.16 squarer: one shift-add step per clock, WIDTH
// steps per operation, valid/ready on both sides, one operation in flight.
// Build option: FIXP_SQUARE_ROUND_EN (handled in fixp_sat_round) selects
// round-to-nearest instead of truncation.
module fixp_square_iter
  import fixp_pkg::*;
#(
  parameter int WIDTH = FIXP_WIDTH,
  parameter int FRAC  = FIXP_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] squarer,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] squared,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  fixp_state_t        r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_squared;
  logic               r_overflow;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_sat_result;
  logic               w_sat_overflow;

  // Accumulator after the current step; on the last step this is the full product.
  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  end

  fixp_sat_round #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sat_round (
    .i_full     (w_acc_next),
    .o_result   (w_sat_result),
    .o_overflow (w_sat_overflow)
  );

  // Control FSM and shift-add datapath with registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch;
    // the datapath registers are cleared too so an aborted operation leaves
    // no stale partial product behind.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_squared   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the values from before this edge regardless of statement order.
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= {{WIDTH{1'b0}}, squarer};
            r_mplier   <= squarer;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_squared   <= w_sat_result;
            r_overflow  <= w_sat_overflow;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign squared   = r_squared;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fixp_square_iter.sv
// Self-checking bench for fixp_square_iter: directed cases, randomized
// operands against an arithmetic reference, backpressure and mid-operation
// reset. Honors FIXP_SQUARE_ROUND_EN the same way the design does.
module tb_fixp_square_iter;

  localparam int WIDTH   = 32;
  localparam int FRAC    = 16;
  localparam int LATENCY = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] squarer;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] squared;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  fixp_square_iter #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .squarer   (squarer),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .squared   (squared),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact product, optional half-LSB rounding, shift, saturate.
  task automatic ref_square(input logic [31:0] x, output logic [31:0] y, output logic ov);
    logic [64:0] full;
    logic [64:0] q;
    full = 65'(x) * 65'(x);
`ifdef FIXP_SQUARE_ROUND_EN
    full = full + 65'(32768);
`endif
    q  = full >> FRAC;
    ov = (q > 65'h0_FFFF_FFFF);
    y  = ov ? 32'hFFFF_FFFF : q[31:0];
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction, entered and left on a falling edge.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] exp_y,
                        input logic exp_ov, input int hold);
    int n;
    int bad;
    logic [31:0] held;
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    squarer   = x;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    cycle();
    in_valid = 1'b0;
    check({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < LATENCY + 8) begin
      cycle();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(LATENCY));
    check({tag, " squared"}, 64'(squared), 64'(exp_y));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ov));
    if (hold > 0) begin
      held     = squared;
      bad      = 0;
      squarer  = ~x;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        cycle();
        if (squared !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      check({tag, " backpressure_hold"}, 64'(bad), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    cycle();
    check({tag, " out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] ey;
    logic        eov;
    int          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    squarer   = '0;
    repeat (3) cycle();
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset squared", 64'(squared), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Directed cases with hand-derived results.
    run_op("x=2.0",      32'h00020000, 32'h00040000, 1'b0, 0);
    run_op("x=1.5",      32'h00018000, 32'h00024000, 1'b0, 0);
    run_op("x=0x100",    32'h00000100, 32'h00000001, 1'b0, 0);
    run_op("x=0",        32'h00000000, 32'h00000000, 1'b0, 0);
    run_op("x=256.0",    32'h01000000, 32'hFFFFFFFF, 1'b1, 0);
    run_op("x=0xFFFFFF", 32'h00FFFFFF, 32'hFFFFFE00, 1'b0, 0);
`ifdef FIXP_SQUARE_ROUND_EN
    run_op("x=0x160",    32'h00000160, 32'h00000002, 1'b0, 0);
`else
    run_op("x=0x160",    32'h00000160, 32'h00000001, 1'b0, 0);
`endif

    // Backpressure: result held for 10 cycles, new operand ignored.
    run_op("bp x=3.0", 32'h00030000, 32'h00090000, 1'b0, 10);

    // Mid-operation reset: abort after 15 CALC cycles.
    squarer  = 32'h00050000;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (15) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort squared", 64'(squared), 64'd0);
    check("abort overflow", 64'(overflow), 64'd0);
    seen = 0;
    for (int i = 0; i < LATENCY + 8; i++) begin
      cycle();
      if (out_valid) seen++;
    end
    check("abort no_result", 64'(seen), 64'd0);
    run_op("post-abort x=3.0", 32'h00030000, 32'h00090000, 1'b0, 0);

    // Randomized operands across small, mid and full ranges.
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       x = $urandom_range(0, 32'h0003FFFF);
        1:       x = $urandom >> ($urandom_range(7, 12));
        default: x = $urandom;
      endcase
      ref_square(x, ey, eov);
      run_op($sformatf("rand%0d x=%h", i, x), x, ey, eov, (i == 5) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
